// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: holds the word PC, requests the instruction from memory,
// and presents the fetched word to decode under a valid/ready handshake.
module pc_fetch_unit #(
  parameter logic [29:0] RESET_PC = 30'h0000_0000,
  parameter int          N        = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [29:0]   nxtPC,
  output logic [29:0]   pc,
  output logic          imem_req,
  output logic [29:0]   imem_addr,
  input  logic          imem_ack,
  input  logic [N-1:0]  imem_rdata,
  output logic [N-1:0]  instr,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [31:0]   fetch_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] VALID = 2'd2;

  logic [1:0]   state;
  logic [29:0]  pc_p0;
  logic [N-1:0] instr_p0;
  logic         vld_p0;
  logic [31:0]  count_p0;

  // Fetch/present loop: registers change only on reset, ack in FETCH, or accept in VALID
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc_p0    <= RESET_PC;
      instr_p0 <= '0;
      vld_p0   <= 1'b0;
      count_p0 <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
        end
        FETCH: begin
          if (imem_ack) begin
            instr_p0 <= imem_rdata;
            vld_p0   <= 1'b1;
            state    <= VALID;
          end
        end
        VALID: begin
          if (instr_ready) begin
            pc_p0    <= nxtPC;
            vld_p0   <= 1'b0;
            count_p0 <= count_p0 + 32'd1;
            state    <= FETCH;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign imem_req    = (state == FETCH);
  assign pc          = pc_p0;
  assign imem_addr   = pc_p0;
  assign instr       = instr_p0;
  assign instr_valid = vld_p0;
  assign fetch_count = count_p0;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: vector table through a scoreboard queue, then hand-written
// sequences for count wrap and reset priority.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [29:0] nxtPC = '0;
  logic [29:0] pc;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] fetch_count;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pc_fetch_unit #(.RESET_PC(30'h100), .N(32)) dut (
    .clk(clk), .rst(rst), .nxtPC(nxtPC), .pc(pc), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .fetch_count(fetch_count)
  );

  typedef struct {
    logic        rst;
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic [29:0] nxt;
    logic [29:0] e_pc;
    logic        e_req;
    logic        e_vld;
    logic [31:0] e_instr;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic add(input logic r, input logic a, input logic [31:0] d, input logic rdy,
                     input logic [29:0] nx, input logic [29:0] p, input logic q,
                     input logic v, input logic [31:0] ins, input logic [31:0] c);
    vec_t t;
    t = '{r, a, d, rdy, nx, p, q, v, ins, c};
    tbl.push_back(t);
  endtask

  initial begin
    vec_t e;
    int waited;
    // rst ack rdata ready nxtPC | pc req vld instr count (after the edge)
    add(1, 0, 32'h0,        0, 30'h0,        30'h100, 0, 0, 32'h0,        0);
    add(1, 0, 32'h0,        0, 30'h0,        30'h100, 0, 0, 32'h0,        0);
    add(1, 0, 32'h0,        0, 30'h0,        30'h100, 0, 0, 32'h0,        0);
    add(0, 0, 32'h0,        0, 30'h0,        30'h100, 1, 0, 32'h0,        0);
    add(0, 1, 32'hA0,       1, 30'h101,      30'h100, 0, 1, 32'hA0,       0);
    add(0, 1, 32'hEE,       1, 30'h101,      30'h101, 1, 0, 32'hA0,       1);
    add(0, 1, 32'hA1,       1, 30'h102,      30'h101, 0, 1, 32'hA1,       1);
    add(0, 1, 32'hEE,       1, 30'h102,      30'h102, 1, 0, 32'hA1,       2);
    add(0, 1, 32'hA2,       1, 30'h103,      30'h102, 0, 1, 32'hA2,       2);
    add(0, 1, 32'hEE,       1, 30'h103,      30'h103, 1, 0, 32'hA2,       3);
    add(0, 1, 32'hB0,       0, 30'h200,      30'h103, 0, 1, 32'hB0,       3);
    add(0, 1, 32'hC1,       0, 30'h200,      30'h103, 0, 1, 32'hB0,       3);
    add(0, 1, 32'hC2,       0, 30'h200,      30'h103, 0, 1, 32'hB0,       3);
    add(0, 1, 32'hC3,       0, 30'h200,      30'h103, 0, 1, 32'hB0,       3);
    add(0, 1, 32'hC4,       0, 30'h200,      30'h103, 0, 1, 32'hB0,       3);
    add(0, 1, 32'hC5,       0, 30'h200,      30'h103, 0, 1, 32'hB0,       3);
    add(0, 0, 32'hC6,       1, 30'h200,      30'h200, 1, 0, 32'hB0,       4);
    add(0, 0, 32'hD1,       1, 30'h3FF,      30'h200, 1, 0, 32'hB0,       4);
    add(0, 0, 32'hD2,       1, 30'h3FF,      30'h200, 1, 0, 32'hB0,       4);
    add(0, 0, 32'hD3,       1, 30'h3FF,      30'h200, 1, 0, 32'hB0,       4);
    add(0, 0, 32'hD4,       1, 30'h3FF,      30'h200, 1, 0, 32'hB0,       4);
    add(0, 1, 32'h8C220004, 0, 30'h3FF,      30'h200, 0, 1, 32'h8C220004, 4);
    add(0, 0, 32'h0,        1, 30'h3FFFFFFF, 30'h3FFFFFFF, 1, 0, 32'h8C220004, 5);
    add(0, 1, 32'hD0,       0, 30'h0,        30'h3FFFFFFF, 0, 1, 32'hD0,  5);
    add(0, 0, 32'h0,        1, 30'h0,        30'h0,   1, 0, 32'hD0,       6);
    add(1, 1, 32'hE0,       0, 30'h0,        30'h100, 0, 0, 32'h0,        0);
    add(0, 0, 32'h0,        0, 30'h0,        30'h100, 1, 0, 32'h0,        0);
    add(0, 1, 32'hF0,       0, 30'h0,        30'h100, 0, 1, 32'hF0,       0);
    add(0, 0, 32'h0,        1, 30'h101,      30'h101, 1, 0, 32'hF0,       1);
    add(0, 1, 32'hF1,       0, 30'h0,        30'h101, 0, 1, 32'hF1,       1);
    add(1, 0, 32'h0,        1, 30'h300,      30'h100, 0, 0, 32'h0,        0);
    add(0, 1, 32'h77,       1, 30'h300,      30'h100, 1, 0, 32'h0,        0);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst; imem_ack = tbl[i].ack; imem_rdata = tbl[i].rdata;
      instr_ready = tbl[i].ready; nxtPC = tbl[i].nxt;
      exp_q.push_back(tbl[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check($sformatf("v%0d pc", i), 64'(pc), 64'(e.e_pc));
      check($sformatf("v%0d imem_addr", i), 64'(imem_addr), 64'(e.e_pc));
      check($sformatf("v%0d imem_req", i), 64'(imem_req), 64'(e.e_req));
      check($sformatf("v%0d instr_valid", i), 64'(instr_valid), 64'(e.e_vld));
      check($sformatf("v%0d instr", i), 64'(instr), 64'(e.e_instr));
      check($sformatf("v%0d fetch_count", i), 64'(fetch_count), 64'(e.e_cnt));
    end

    // fetch_count wrap: preset the counter while in FETCH, then one accept
    @(negedge clk);
    force dut.count_p0 = 32'hFFFF_FFFF;
    imem_ack = 1'b1; imem_rdata = 32'h1234; instr_ready = 1'b0; nxtPC = 30'h55;
    @(posedge clk);
    #1;
    release dut.count_p0;
    check("wrap preset count", 64'(fetch_count), 64'hFFFF_FFFF);
    check("wrap instr_valid", 64'(instr_valid), 64'd1);
    @(negedge clk);
    imem_ack = 1'b0; instr_ready = 1'b1;
    @(posedge clk);
    #1;
    check("wrap count to zero", 64'(fetch_count), 64'd0);
    check("wrap pc", 64'(pc), 64'h55);

    // reset with a same-cycle ack in FETCH
    @(negedge clk);
    instr_ready = 1'b0;
    check("rstprio in fetch", 64'(imem_req), 64'd1);
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hBAD;
    @(posedge clk);
    #1;
    check("rstprio instr_valid", 64'(instr_valid), 64'd0);
    check("rstprio state", 64'(dut.state), 64'd0);
    check("rstprio instr", 64'(instr), 64'd0);
    check("rstprio pc", 64'(pc), 64'h100);
    @(negedge clk);
    rst = 1'b0; imem_ack = 1'b0;
    waited = 0;
    while (!imem_req && waited < 10) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("restart req latency", 64'(waited), 64'd1);
    check("restart addr", 64'(imem_addr), 64'h100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 30'h0000_0000, is the word address loaded into the PC on reset.
REQ-002 Parameter N, default 32, is the instruction and data word width.
REQ-003 clk  input  1  is the single clock; all state updates on the rising edge.
REQ-004 rst  input  1  is the reset: synchronous, active-high.
REQ-005 nxtPC  input  30  is the next word address from the next-address generator, sampled only on an accept cycle.
REQ-006 pc  output  30  is the registered word PC of the instruction currently fetched or held; it feeds the next-address generator pc input.
REQ-007 imem_req  output  1  is the instruction-memory read request.
REQ-008 imem_addr  output  30  is the instruction-memory word address; it always equals pc.
REQ-009 imem_ack  input  1  is the memory read completion; imem_rdata is valid in the same cycle.
REQ-010 imem_rdata  input  N  is the instruction word from memory.
REQ-011 instr  output  N  is the registered instruction delivered to decode.
REQ-012 instr_valid  output  1  indicates that instr and pc form a valid fetched pair.
REQ-013 instr_ready  input  1  indicates that the downstream stage accepts the instruction this cycle.
REQ-014 fetch_count  output  32  is the number of instructions accepted since reset.

Function
REQ-015 The block SHALL implement the states IDLE, FETCH and VALID, held in a registered state variable.
REQ-016 On reset the block SHALL enter IDLE with pc=RESET_PC, instr=0, instr_valid=0, fetch_count=0 and imem_req=0.
REQ-017 In IDLE the block SHALL go to FETCH unconditionally on the next edge, so the first request is asserted in the 2nd cycle after rst deasserts.
REQ-018 imem_req SHALL be 1 exactly when state=FETCH, decoded combinationally from the state register.
REQ-019 In FETCH with imem_ack=1 the block SHALL load instr<=imem_rdata, set instr_valid<=1 and enter VALID.
REQ-020 In FETCH with imem_ack=0 the block SHALL hold all registers, with no timeout.
REQ-021 imem_ack in IDLE or VALID SHALL be ignored, with no register change.
REQ-022 In VALID, instr_valid=1 and instr and pc SHALL be held stable while instr_ready=0.
REQ-023 In VALID with instr_ready=1 (the accept cycle) the block SHALL:
- load pc<=nxtPC;
- clear instr_valid;
- increment fetch_count;
- enter FETCH.
REQ-024 instr_ready outside VALID SHALL have no effect.
REQ-025 Minimum throughput SHALL be one instruction per 2 cycles (FETCH with immediate ack, then VALID with immediate ready); the latency from request to instr_valid SHALL be 1 cycle after the ack.
REQ-026 nxtPC SHALL be accepted as any 30-bit value without checking; pc wraps naturally (e.g. 30'h3FFFFFFF followed by incPC gives 0).
REQ-027 fetch_count SHALL wrap from 32'hFFFFFFFF to 0.
REQ-028 instr SHALL be held after acceptance until the next ack; only instr_valid qualifies it.

Reset
REQ-029 rst SHALL take priority over every other input in the same cycle, including imem_ack and instr_ready.
REQ-030 rst asserted mid-fetch (state FETCH) SHALL drop the outstanding request; an ack arriving in the same cycle SHALL be discarded, and the block SHALL return to IDLE with REQ-016 values.
REQ-031 rst asserted while instr_valid=1 SHALL discard the held instruction without incrementing fetch_count.

Verification
REQ-032 The bench SHALL cover the reset/first fetch case: RESET_PC=30'h100 and rst held 3 cycles -> pc=30'h100, imem_req=0 during reset and in the first cycle after, then imem_req=1 with imem_addr=30'h100.
REQ-033 The bench SHALL cover back-to-back flow: ack=1 and ready=1 permanently with nxtPC=pc+1 -> instr_valid pulses every 2nd cycle, pc steps 0x100, 0x101, 0x102, and fetch_count=3 after 3 accepts.
REQ-034 The bench SHALL cover downstream stall: instr_ready=0 for 5 cycles in VALID while imem_rdata changes -> instr and pc remain unchanged, and on ready=1 nxtPC=30'h200 is loaded with pc=30'h200.
REQ-035 The bench SHALL cover memory wait: imem_ack delayed 4 cycles -> imem_req stays 1 and imem_addr stays constant, instr_valid=0, and instr=32'h8C220004 one cycle after the ack.
REQ-036 The bench SHALL cover reset priority: rst and imem_ack both 1 in FETCH -> instr_valid=0 and state=IDLE next cycle; rst with ready in VALID -> fetch_count=0.
REQ-037 The bench SHALL cover wrap: pc=30'h3FFFFFFF accepted with nxtPC=0 -> imem_addr=0; fetch_count preset path 32'hFFFFFFFF plus one accept -> 0.
